// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_pkg
//  Description : Shared types for the dual-requester RAM arbiter. Holds the
//                controller state encoding used by dpram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    // Controller states: arbitrate requesters, or zero-fill the whole RAM.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant logic. Grants are combinational;
//                a 1-bit last-grant pointer decides conflicts in favour of
//                the requester not granted most recently.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_en            - arbitration allowed this cycle
//                i_req0/i_req1   - request lines
//                o_gnt0/o_gnt1   - one-hot (or zero) grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 1 = requester 1 was granted most recently. Resets to 1 so requester 0
    // wins the first conflict.
    logic r_last;

    assign o_gnt0 = i_en & i_req0 & (~i_req1 | r_last);
    assign o_gnt1 = i_en & i_req1 & (~i_req0 | ~r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (o_gnt0 | o_gnt1) begin
            r_last <= o_gnt1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_arbiter
//  Description : Shares one single-port RAM interface between two requesters
//                with round-robin arbitration, and provides a zero-fill
//                sequence that writes every address once.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                reqN_valid/ready/we/addr/wdata - requester N access channel
//                rspN_valid/rdata        - read response, one cycle after grant
//                clear_start/clear_busy  - zero-fill trigger / in progress
//                ram_address/data/enable/wren, ram_q - external RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_enable,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam logic [AW-1:0] C_CNT_LAST = '1;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;
    logic          w_arb_en;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          r_pend0;
    logic          r_pend1;
    logic [DW-1:0] r_hold0;
    logic [DW-1:0] r_hold1;

    // Reset gates every access, so an in-flight clear cannot write the
    // address it was on when reset arrived. clear_start wins over grants.
    assign w_arb_en = (r_state == ST_IDLE) & ~clear_start & ~reset;

    rr_arb2 u_arb (
        .clk    (clock),
        .rst    (reset),
        .i_en   (w_arb_en),
        .i_req0 (req0_valid),
        .i_req1 (req1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign clear_busy = (r_state == ST_CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        ram_address  = '0;
        ram_data     = '0;
        ram_enable   = 1'b0;
        ram_wren     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_next = ST_CLEAR;
                end else if (w_gnt1) begin
                    ram_enable  = 1'b1;
                    ram_wren    = req1_we;
                    ram_address = req1_addr;
                    ram_data    = req1_wdata;
                end else if (w_gnt0) begin
                    ram_enable  = 1'b1;
                    ram_wren    = req0_we;
                    ram_address = req0_addr;
                    ram_data    = req0_wdata;
                end
            end
            ST_CLEAR: begin
                ram_address = r_cnt;
                ram_enable  = ~reset;
                ram_wren    = ~reset;
                w_cnt_next  = r_cnt + AW'(1);
                if (r_cnt == C_CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Read responses: the RAM answers one cycle after a granted read. The
    // hold registers keep the last delivered word visible between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            r_pend0 <= w_gnt0 & ~req0_we;
            r_pend1 <= w_gnt1 & ~req1_we;
            if (r_pend0) begin
                r_hold0 <= ram_q;
            end
            if (r_pend1) begin
                r_hold1 <= ram_q;
            end
        end
    end

    // A response still outstanding while reset is high is dropped.
    assign rsp0_valid = r_pend0 & ~reset;
    assign rsp1_valid = r_pend1 & ~reset;
    assign rsp0_rdata = rsp0_valid ? ram_q : r_hold0;
    assign rsp1_rdata = rsp1_valid ? ram_q : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_arbiter
//  Description : Self-checking bench for dpram_arbiter. A behavioural RAM
//                sits on the ram_* port; a cycle reference model predicts
//                grants, RAM accesses, clear progress and read responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          clear_start, clear_busy;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_enable, ram_wren;
    logic [DW-1:0] ram_q;

    always #5 clock = ~clock;

    dpram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rdata  (rsp0_rdata),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rdata  (rsp1_rdata),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_enable  (ram_enable),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // External single-port RAM, read latency 1.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_enable) begin
            if (ram_wren) ram_mem[ram_address] <= ram_data;
            else          ram_q <= ram_mem[ram_address];
        end
    end

    // Reference model state.
    bit            m_known = 1'b0;
    bit            m_clear;
    int            m_cnt;
    int            m_last;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend  [2];
    logic [DW-1:0] m_pdata [2];
    logic [DW-1:0] m_hold  [2];

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // cycle's outputs, advances the model across the rising edge, and returns
    // at the next falling edge.
    task automatic tick();
        int            g;
        bit            e_en, e_wr, e_rv;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        g = -1; e_en = 0; e_wr = 0; e_a = '0; e_d = '0;
        #1;
        if (!reset) begin
            if (m_clear) begin
                e_en = 1; e_wr = 1; e_a = AW'(m_cnt); e_d = '0;
            end else if (!clear_start) begin
                if (req0_valid && req1_valid) g = 1 - m_last;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
        end
        if (g == 0) begin e_en = 1; e_wr = req0_we; e_a = req0_addr; e_d = req0_wdata; end
        if (g == 1) begin e_en = 1; e_wr = req1_we; e_a = req1_addr; e_d = req1_wdata; end

        if (m_known) begin
            check_eq("req0_ready", req0_ready, g == 0);
            check_eq("req1_ready", req1_ready, g == 1);
            check_eq("ram_enable", ram_enable, e_en);
            check_eq("ram_wren", ram_wren, e_wr);
            if (e_en) check_eq("ram_address", ram_address, e_a);
            if (e_wr) check_eq("ram_data", ram_data, e_d);
            check_eq("clear_busy", clear_busy, m_clear);
            e_rv = m_pend[0] && !reset;
            check_eq("rsp0_valid", rsp0_valid, e_rv);
            check_eq("rsp0_rdata", rsp0_rdata, e_rv ? m_pdata[0] : m_hold[0]);
            e_rv = m_pend[1] && !reset;
            check_eq("rsp1_valid", rsp1_valid, e_rv);
            check_eq("rsp1_rdata", rsp1_rdata, e_rv ? m_pdata[1] : m_hold[1]);
            if (clear_busy) busy_cnt++;
        end

        if (reset) begin
            m_known = 1; m_clear = 0; m_cnt = 0; m_last = 1;
            for (int n = 0; n < 2; n++) begin m_pend[n] = 0; m_hold[n] = '0; end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (m_pend[n]) m_hold[n] = m_pdata[n];
                m_pend[n] = 0;
            end
            if (m_clear) begin
                m_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == DEPTH) begin m_clear = 0; m_cnt = 0; end
            end else if (clear_start) begin
                m_clear = 1;
            end else if (g >= 0) begin
                m_last = g;
                if (e_wr) m_mem[e_a] = e_d;
                else begin m_pend[g] = 1; m_pdata[g] = m_mem[e_a]; end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_in();
        reset = 0; clear_start = 0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input bit v, input bit we, input int a, input int d);
        req0_valid = v; req0_we = we; req0_addr = AW'(a); req0_wdata = DW'(d);
    endtask

    task automatic drive1(input bit v, input bit we, input int a, input int d);
        req1_valid = v; req1_we = we; req1_addr = AW'(a); req1_wdata = DW'(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
        ram_q = '0;
        idle_in();
        reset = 1;
        @(negedge clock);
        tick();                       // establishes known state
        tick();                       // reset-state outputs checked
        idle_in();
        tick();

        // Write via req0, read back via req1.
        drive0(1, 1, 'h10, 'h5A); tick();
        idle_in();                tick();
        drive1(1, 0, 'h10, 0);    tick();
        idle_in();                tick();
        check_eq("rsp1_rdata_5a", rsp1_rdata, 8'h5A);

        // Both requesters with reads pending: alternating grants.
        drive0(1, 0, 'h10, 0); drive1(1, 0, 'h11, 0);
        repeat (4) tick();
        idle_in(); tick();

        // Only req1 requesting.
        drive1(1, 1, 'h20, 'h33); tick();
        for (int i = 0; i < 5; i++) begin drive1(1, i[0], 'h20 + i, i); tick(); end
        idle_in(); tick();

        // Fill with 0xFF, clear, read everything back.
        for (int i = 0; i < DEPTH; i++) begin drive0(1, 1, i, 'hFF); tick(); end
        idle_in(); clear_start = 1; busy_cnt = 0; tick();
        clear_start = 0;
        drive1(1, 0, 'h05, 0);        // held through the clear; must stay ungranted
        for (int i = 0; i < 300; i++) begin
            clear_start = (i == 40);  // ignored while clearing
            tick();
        end
        check_eq("clear_len", busy_cnt, DEPTH);
        idle_in();
        for (int i = 0; i < DEPTH; i++) begin drive0(1, 0, i, 0); tick(); end
        idle_in(); tick();

        // Reset in the middle of a clear leaves untouched addresses intact.
        drive0(1, 1, 100, 'hC3); tick();
        idle_in(); clear_start = 1; tick();
        clear_start = 0;
        repeat (100) tick();
        reset = 1; tick();
        reset = 0; tick();
        drive0(1, 0, 100, 0); tick();
        idle_in(); tick();
        check_eq("rsp0_after_abort", rsp0_rdata, 8'hC3);

        // clear_start together with a request: request waits for the clear.
        drive0(1, 0, 'h07, 0); clear_start = 1; tick();
        clear_start = 0;
        repeat (DEPTH + 2) tick();
        idle_in(); tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            clear_start = ($urandom_range(0, 399) == 0);
            drive0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31), $urandom);
            drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31), $urandom);
            tick();
        end
        idle_in(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter AW, default 8, RAM address width in bits.
REQ-002 Parameter DW, default 8, RAM data width in bits.
REQ-003 Ports: clock and reset first.
- clock  in  1  single clock for all logic and the shared RAM port.
- reset  in  1  synchronous, active-high.
- req0_valid / req1_valid  in  1  requester n has an access pending.
- req0_ready / req1_ready  out  1  access accepted this cycle.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  AW  access address.
- req0_wdata / req1_wdata  in  DW  write data.
- rsp0_valid / rsp1_valid  out  1  read data valid for requester n.
- rsp0_rdata / rsp1_rdata  out  DW  read data.
- clear_start  in  1  pulse that starts a zero-fill of the whole RAM.
- clear_busy  out  1  zero-fill in progress.
- ram_address  out  AW  drives dpram address_a.
- ram_data  out  DW  drives dpram data_a.
- ram_enable  out  1  drives dpram enable_a.
- ram_wren  out  1  drives dpram wren_a.
- ram_q  in  DW  dpram q_a, read latency 1.

Function
REQ-004 The block shall arbitrate requester 0 and requester 1 onto one RAM port, granting at most one access per cycle.
REQ-005 readyn shall be combinational: it is high in the cycle requester n is granted. A transfer occurs when valid and ready are both high.
REQ-006 If only one requester is valid, that requester shall be granted in the same cycle.
REQ-007 If both are valid, grant shall be round-robin:
- a 1-bit last-grant pointer selects the requester not granted most recently;
- the pointer updates on every transfer;
- the pointer resets to 1, so requester 0 wins the first conflict.
REQ-008 On a transfer, ram_address, ram_data and ram_wren shall be the granted requester's addr, wdata and we, with ram_enable=1; otherwise ram_enable=0 and ram_wren=0.
REQ-009 A granted read shall assert rspn_valid exactly 1 cycle later for one cycle, with rspn_rdata=ram_q. Writes produce no response.
REQ-010 rspn_rdata shall hold its last value when rspn_valid=0.
REQ-011 The state machine shall have two states: IDLE (arbitrate) and CLEAR.
REQ-012 In IDLE, clear_start=1 shall enter CLEAR next cycle. clear_start takes precedence: no grant is issued in that cycle.
REQ-013 In CLEAR:
- a counter from 0 to 2^AW-1 shall drive ram_address, with ram_data=0 and ram_wren=ram_enable=1;
- both readys shall be 0;
- clear_busy shall be 1;
- after the write to address 2^AW-1 the block returns to IDLE, so CLEAR lasts exactly 2^AW cycles.
REQ-014 clear_start while in CLEAR shall be ignored; the counter does not restart.
REQ-015 A read response due in the first CLEAR cycle shall still be delivered.

Reset
REQ-016 reset shall abort any operation. On the next edge:
- state=IDLE, counter=0, pointer=1;
- all readys, rsp valids, clear_busy, ram_enable and ram_wren = 0;
- rsp rdata = 0.
REQ-017 A response pending when reset is applied shall be discarded.

Structure
REQ-018 The state enum (IDLE, CLEAR) shall be defined in the shared package dpram_pkg.
REQ-019 One sub-module shall be used: rr_arb2, the 2-way round-robin grant logic with pointer.
REQ-020 The dpram instance shall live outside this block, connected through the ram_* ports.

Verification
REQ-021 Write 0x5A to addr 0x10 via req0, then read 0x10 via req1: rsp1_valid 1 cycle after the read grant, rsp1_rdata=0x5A.
REQ-022 Both requesters hold valid reads for 4 cycles: grants go 0,1,0,1 and each rsp arrives 1 cycle after its grant.
REQ-023 Only req1 valid continuously: req1_ready=1 every cycle, and req0 is never granted.
REQ-024 Fill the RAM with 0xFF, pulse clear_start, read every address: clear_busy=1 for exactly 256 cycles (AW=8), all reads return 0x00, readys=0 throughout.
REQ-025 Assert reset at clear counter 100: next cycle clear_busy=0 and state=IDLE; addr 100 still reads its pre-clear value.
REQ-026 clear_start in the same cycle as req0_valid: req0_ready=0, CLEAR is entered, and req0 is granted in the first IDLE cycle after the clear.
